fifo_ram_ctrl: RTL and testbench

Storage and read-control stage of the FSM-based FIFO. Holds a 2^addr_bits-deep RAM with write/read pointers, occupancy count and full/empty flags. Each accepted read fetches one word into a registered output and raises a one-cycle load strobe. That output and strobe drive the data input and load enable of the downstream read buffer register.

---
 rtl/fifo_ram_ctrl.sv | 121 ++++++++++++
 tb/tb_fifo_ram_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ram_ctrl.sv
// Storage and read-control stage of the FIFO: RAM, pointers, occupancy and a
// two-state read FSM whose registered word and strobe feed the read buffer.
module fifo_ram_ctrl #(
    parameter int width     = 7,
    parameter int addr_bits = 3
) (
    input  logic                 clk,
    input  logic                 Clear,
    input  logic [width:0]       data_in,
    input  logic                 wr_req,
    input  logic                 rd_req,
    output logic [width:0]       data_out,
    output logic                 LoadEnable,
    output logic                 full,
    output logic                 empty,
    output logic [addr_bits:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 1 << addr_bits;
    localparam logic [addr_bits:0] DEPTH_C = (addr_bits + 1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    logic [width:0]         mem [DEPTH];

    logic [addr_bits-1:0]   wptr_q, wptr_d;
    logic [addr_bits-1:0]   rptr_q, rptr_d;
    logic [addr_bits:0]     count_q, count_d;
    state_t                 state_q, state_d;
    logic [width:0]         dout_q, dout_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   wr_ok_s;
    logic                   rd_ok_s;

    // Accept decisions and next-state logic; flags look only at the current count.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        state_d = state_q;
        dout_d  = dout_q;
        wr_ok_s = wr_req & ~full_q;
        rd_ok_s = rd_req & ~empty_q;
        ovf_d   = wr_req & full_q;
        unf_d   = rd_req & empty_q;

        if (wr_ok_s) begin
            wptr_d = wptr_q + addr_bits'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (rd_ok_s) begin
            rptr_d  = rptr_q + addr_bits'(1);
            dout_d  = mem[rptr_q];
            state_d = LOAD;
        end else begin
            rptr_d  = rptr_q;
            dout_d  = dout_q;
            state_d = IDLE;
        end

        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + (addr_bits + 1)'(1);
            2'b01:   count_d = count_q - (addr_bits + 1)'(1);
            default: count_d = count_q;
        endcase

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge Clear) begin
        if (!Clear) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            dout_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            dout_q  <= dout_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // RAM array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem[wptr_q] <= data_in;
        end
    end

    assign data_out   = dout_q;
    assign LoadEnable = (state_q == LOAD);
    assign full       = full_q;
    assign empty      = empty_q;
    assign count      = count_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench for fifo_ram_ctrl: queue-based reference model, directed
// scenarios with literal expectations, then a randomized run.
module tb_fifo_ram_ctrl;

    logic       clk;
    logic       Clear;
    logic [7:0] data_in;
    logic       wr_req;
    logic       rd_req;
    logic [7:0] data_out;
    logic       LoadEnable;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    fifo_ram_ctrl #(.width(7), .addr_bits(3)) dut (
        .clk        (clk),
        .Clear      (Clear),
        .data_in    (data_in),
        .wr_req     (wr_req),
        .rd_req     (rd_req),
        .data_out   (data_out),
        .LoadEnable (LoadEnable),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [7:0] q[$];
    logic [7:0] exp_dout;
    logic       exp_le;
    logic       exp_ovf;
    logic       exp_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = 8'h00;
        exp_le   = 1'b0;
        exp_ovf  = 1'b0;
        exp_unf  = 1'b0;
    endtask

    // One clock edge of the FIFO as seen from outside.
    task automatic model_edge(input logic w, input logic r, input logic [7:0] d);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == 8);
        was_empty = (q.size() == 0);
        exp_ovf   = w && was_full;
        exp_unf   = r && was_empty;
        exp_le    = r && !was_empty;
        if (r && !was_empty) exp_dout = q.pop_front();
        if (w && !was_full) q.push_back(d);
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr_req  = w;
        rd_req  = r;
        data_in = d;
        @(posedge clk);
        model_edge(w, r, d);
        @(negedge clk);
    endtask

    // Asserts Clear partway through the low phase and checks outputs at once.
    task automatic pulse_reset();
        #2;
        Clear = 1'b0;
        model_reset();
        #1;
        chk("rst_dout", {24'h0, data_out}, 32'h0);
        chk("rst_le", {31'h0, LoadEnable}, 32'h0);
        chk("rst_count", {28'h0, count}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full", {31'h0, full}, 32'h0);
        chk("rst_ovf_unf", {30'h0, overflow, underflow}, 32'h0);
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_req = 1'b0;
        rd_req = 1'b0;
        Clear  = 1'b1;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("dout", {24'h0, data_out}, {24'h0, exp_dout});
            chk("le", {31'h0, LoadEnable}, {31'h0, exp_le});
            chk("count", {28'h0, count}, q.size());
            chk("full", {31'h0, full}, {31'h0, (q.size() == 8)});
            chk("empty", {31'h0, empty}, {31'h0, (q.size() == 0)});
            chk("ovf", {31'h0, overflow}, {31'h0, exp_ovf});
            chk("unf", {31'h0, underflow}, {31'h0, exp_unf});
        end
    end

    initial begin
        Clear   = 1'b1;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        data_in = 8'h00;
        model_reset();
        @(negedge clk);
        pulse_reset();

        // Three writes then three reads.
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        chk("t1_count3", {28'h0, count}, 32'h3);
        chk("t1_notempty", {31'h0, empty}, 32'h0);
        step(1'b0, 1'b1, 8'h00);
        chk("t1_rd0", {23'h0, LoadEnable, data_out}, 32'h111);
        step(1'b0, 1'b1, 8'h00);
        chk("t1_rd1", {23'h0, LoadEnable, data_out}, 32'h122);
        step(1'b0, 1'b1, 8'h00);
        chk("t1_rd2", {23'h0, LoadEnable, data_out}, 32'h133);
        step(1'b0, 1'b0, 8'h00);
        chk("t1_idle", {26'h0, LoadEnable, empty, count}, 32'h10);

        // Fill, overflow, drain.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i));
        chk("t2_full", {27'h0, full, count}, 32'h18);
        step(1'b1, 1'b0, 8'hFF);
        chk("t2_ovf", {27'h0, overflow, count}, 32'h18);
        step(1'b0, 1'b0, 8'h00);
        chk("t2_ovf_end", {31'h0, overflow}, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("t2_drain", {24'h0, data_out}, i);
        end
        step(1'b0, 1'b0, 8'h00);

        // Underflow right after reset.
        pulse_reset();
        step(1'b0, 1'b1, 8'h00);
        chk("t3_unf", {26'h0, underflow, LoadEnable, count}, 32'h20);
        chk("t3_dout", {24'h0, data_out}, 32'h0);
        step(1'b0, 1'b0, 8'h00);
        chk("t3_unf_end", {31'h0, underflow}, 32'h0);

        // Wrap-around in groups of 5/5/2.
        begin
            int wk;
            int rk;
            wk = 0;
            rk = 0;
            for (int g = 0; g < 3; g++) begin
                int n;
                n = (g == 2) ? 2 : 5;
                for (int i = 0; i < n; i++) begin
                    step(1'b1, 1'b0, 8'(8'hA0 + wk));
                    wk++;
                end
                for (int i = 0; i < n; i++) begin
                    step(1'b0, 1'b1, 8'h00);
                    chk("t4_wrap", {24'h0, data_out}, 32'hA0 + rk);
                    rk++;
                end
            end
            step(1'b0, 1'b0, 8'h00);
            chk("t4_final", {28'h0, count}, 32'h0);
        end

        // Simultaneous read and write at count 4.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 8'(8'h50 + i));
            chk("t5_both", {22'h0, overflow, underflow, data_out}, 32'h40 + i);
            chk("t5_count", {28'h0, count}, 32'h4);
        end
        step(1'b0, 1'b0, 8'h00);

        // Reset in the middle of a read stream at count 5.
        pulse_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        pulse_reset();
        chk("t6_after", {27'h0, empty, count}, 32'h10);
        step(1'b0, 1'b1, 8'h00);
        chk("t6_unf", {31'h0, underflow}, 32'h1);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
            end else begin
                int bias;
                bias = (n / 100) % 3;
                step(($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5))),
                     ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5))),
                     8'($urandom));
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
